// File: rtl/dsky_relay_decoder_pkg.sv
// Shared constants for the DSKY relay decoder: relay-word addresses,
// 5-bit relay digit codes, special digit values and DSKY_DIGITS slot indices.
package dsky_pkg;

  localparam logic [3:0] RW_R3LO  = 4'd1;
  localparam logic [3:0] RW_R3MID = 4'd2;
  localparam logic [3:0] RW_R2R3  = 4'd3;
  localparam logic [3:0] RW_R2LO  = 4'd4;
  localparam logic [3:0] RW_R2HI  = 4'd5;
  localparam logic [3:0] RW_R1LO  = 4'd6;
  localparam logic [3:0] RW_R1HI  = 4'd7;
  localparam logic [3:0] RW_R1D1  = 4'd8;
  localparam logic [3:0] RW_NOUN  = 4'd9;
  localparam logic [3:0] RW_VERB  = 4'd10;
  localparam logic [3:0] RW_MODE  = 4'd11;
  localparam logic [3:0] RW_LAMPS = 4'd12;

  localparam logic [4:0] RC_0     = 5'd21;
  localparam logic [4:0] RC_1     = 5'd3;
  localparam logic [4:0] RC_2     = 5'd25;
  localparam logic [4:0] RC_3     = 5'd27;
  localparam logic [4:0] RC_4     = 5'd15;
  localparam logic [4:0] RC_5     = 5'd30;
  localparam logic [4:0] RC_6     = 5'd28;
  localparam logic [4:0] RC_7     = 5'd19;
  localparam logic [4:0] RC_8     = 5'd29;
  localparam logic [4:0] RC_9     = 5'd31;
  localparam logic [4:0] RC_BLANK = 5'd0;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_BAD   = 4'hE;

  localparam int NUM_DIGITS = 21;
  localparam int DG_MD1  = 0;
  localparam int DG_MD2  = 1;
  localparam int DG_VD1  = 2;
  localparam int DG_VD2  = 3;
  localparam int DG_ND1  = 4;
  localparam int DG_ND2  = 5;
  localparam int DG_R1D1 = 6;
  localparam int DG_R1D2 = 7;
  localparam int DG_R1D3 = 8;
  localparam int DG_R1D4 = 9;
  localparam int DG_R1D5 = 10;
  localparam int DG_R2D1 = 11;
  localparam int DG_R2D2 = 12;
  localparam int DG_R2D3 = 13;
  localparam int DG_R2D4 = 14;
  localparam int DG_R2D5 = 15;
  localparam int DG_R3D1 = 16;
  localparam int DG_R3D2 = 17;
  localparam int DG_R3D3 = 18;
  localparam int DG_R3D4 = 19;
  localparam int DG_R3D5 = 20;

endpackage

// File: rtl/dsky_relay_decoder_if.sv
// AGC-to-DSKY relay bundle: relay-word address, relay data and the
// verb/noun flash line. The AGC side drives (master), the DSKY listens (slave).
interface dsky_relay_decoder_if;
  logic RYWD12, RYWD13, RYWD14, RYWD16;
  logic RLYB01, RLYB02, RLYB03, RLYB04, RLYB05, RLYB06;
  logic RLYB07, RLYB08, RLYB09, RLYB10, RLYB11;
  logic VNFLSH;

  modport master (
    output RYWD12, RYWD13, RYWD14, RYWD16,
    output RLYB01, RLYB02, RLYB03, RLYB04, RLYB05, RLYB06,
    output RLYB07, RLYB08, RLYB09, RLYB10, RLYB11,
    output VNFLSH
  );

  modport slave (
    input RYWD12, RYWD13, RYWD14, RYWD16,
    input RLYB01, RLYB02, RLYB03, RLYB04, RLYB05, RLYB06,
    input RLYB07, RLYB08, RLYB09, RLYB10, RLYB11,
    input VNFLSH
  );
endinterface

// File: rtl/dsky_relay_decoder_digit_decode.sv
// Converts one 5-bit DSKY relay digit code into BCD; 0 is a blank digit,
// any unrecognised code reads as DIGIT_BAD.
module dsky_digit_decode
  import dsky_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [3:0] o_bcd
);

  always_comb begin
    case (i_code)
      RC_0:     o_bcd = 4'd0;
      RC_1:     o_bcd = 4'd1;
      RC_2:     o_bcd = 4'd2;
      RC_3:     o_bcd = 4'd3;
      RC_4:     o_bcd = 4'd4;
      RC_5:     o_bcd = 4'd5;
      RC_6:     o_bcd = 4'd6;
      RC_7:     o_bcd = 4'd7;
      RC_8:     o_bcd = 4'd8;
      RC_9:     o_bcd = 4'd9;
      RC_BLANK: o_bcd = DIGIT_BLANK;
      default:  o_bcd = DIGIT_BAD;
    endcase
  end

endmodule

// File: rtl/dsky_relay_decoder.sv
// DSKY relay-word decoder: synchronizes and debounces the AGC relay lines,
// keeps the 12-word relay file and registers the decoded display. Option: VNFLSH_BLANK_EN.
module dsky_relay_decoder
  import dsky_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                   SIM_CLK,
  input  logic                   SIM_RST_n,
  dsky_relay_decoder_if.slave    relay,
  output logic [4*NUM_DIGITS-1:0] DSKY_DIGITS,
  output logic [2:0]             DSKY_PLUS,
  output logic [2:0]             DSKY_MINUS,
  output logic [10:0]            DSKY_LAMPS,
  output logic                   WORD_STB,
  output logic [3:0]             WORD_ADDR
);

  localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 1);

  logic [15:0] w_raw;
  logic [15:0] r_sync [SYNC_STAGES];
  logic [14:0] w_pat;
  logic [3:0]  w_addr;
  logic [10:0] w_data;
  logic [14:0] r_prev;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nx;
  logic        w_accept;

  logic [10:0] r_word  [1:12];
  logic [10:0] w_word_nx [1:12];
  logic [4:0]  w_code  [NUM_DIGITS];
  logic [3:0]  w_bcd   [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] w_digits;

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [2:0]  r_plus, r_minus;
  logic [10:0] r_lamps;
  logic        r_stb;
  logic [3:0]  r_waddr;

  assign w_raw = {relay.RYWD16, relay.RYWD14, relay.RYWD13, relay.RYWD12,
                  relay.RLYB11, relay.RLYB10, relay.RLYB09, relay.RLYB08,
                  relay.RLYB07, relay.RLYB06, relay.RLYB05, relay.RLYB04,
                  relay.RLYB03, relay.RLYB02, relay.RLYB01, relay.VNFLSH};

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_pat  = r_sync[SYNC_STAGES-1][15:1];
  assign w_addr = w_pat[14:11];
  assign w_data = w_pat[10:0];

  // Stability filter: the accept point is hit only once per run of an unchanged pattern.
  always_comb begin
    if (w_pat != r_prev)       w_cnt_nx = 8'd0;
    else if (r_cnt == 8'hFF)   w_cnt_nx = 8'hFF;
    else                       w_cnt_nx = r_cnt + 8'd1;
  end

  assign w_accept = (w_cnt_nx == ACC_CNT) && (w_addr >= RW_R3LO) && (w_addr <= RW_LAMPS);

  always_comb begin
    for (int i = 1; i <= 12; i++) begin
      w_word_nx[i] = r_word[i];
      if (w_accept && (w_addr == 4'(i))) w_word_nx[i] = w_data;
    end
  end

  // Decode from the next-state word file so the display lands with WORD_STB.
  always_comb begin
    w_code[DG_MD1]  = w_word_nx[RW_MODE][9:5];
    w_code[DG_MD2]  = w_word_nx[RW_MODE][4:0];
    w_code[DG_VD1]  = w_word_nx[RW_VERB][9:5];
    w_code[DG_VD2]  = w_word_nx[RW_VERB][4:0];
    w_code[DG_ND1]  = w_word_nx[RW_NOUN][9:5];
    w_code[DG_ND2]  = w_word_nx[RW_NOUN][4:0];
    w_code[DG_R1D1] = w_word_nx[RW_R1D1][4:0];
    w_code[DG_R1D2] = w_word_nx[RW_R1HI][9:5];
    w_code[DG_R1D3] = w_word_nx[RW_R1HI][4:0];
    w_code[DG_R1D4] = w_word_nx[RW_R1LO][9:5];
    w_code[DG_R1D5] = w_word_nx[RW_R1LO][4:0];
    w_code[DG_R2D1] = w_word_nx[RW_R2HI][9:5];
    w_code[DG_R2D2] = w_word_nx[RW_R2HI][4:0];
    w_code[DG_R2D3] = w_word_nx[RW_R2LO][9:5];
    w_code[DG_R2D4] = w_word_nx[RW_R2LO][4:0];
    w_code[DG_R2D5] = w_word_nx[RW_R2R3][9:5];
    w_code[DG_R3D1] = w_word_nx[RW_R2R3][4:0];
    w_code[DG_R3D2] = w_word_nx[RW_R3MID][9:5];
    w_code[DG_R3D3] = w_word_nx[RW_R3MID][4:0];
    w_code[DG_R3D4] = w_word_nx[RW_R3LO][9:5];
    w_code[DG_R3D5] = w_word_nx[RW_R3LO][4:0];
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    dsky_digit_decode u_dec (
      .i_code (w_code[g]),
      .o_bcd  (w_bcd[g])
    );
  end

  always_comb begin
    for (int g = 0; g < NUM_DIGITS; g++) w_digits[4*g +: 4] = w_bcd[g];
`ifdef VNFLSH_BLANK_EN
    if (r_sync[SYNC_STAGES-1][0]) begin
      w_digits[4*DG_VD1 +: 4] = DIGIT_BLANK;
      w_digits[4*DG_VD2 +: 4] = DIGIT_BLANK;
      w_digits[4*DG_ND1 +: 4] = DIGIT_BLANK;
      w_digits[4*DG_ND2 +: 4] = DIGIT_BLANK;
    end
`endif
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      r_prev   <= '0;
      r_cnt    <= '0;
      for (int i = 1; i <= 12; i++) r_word[i] <= '0;
      r_digits <= {NUM_DIGITS{DIGIT_BLANK}};
      r_plus   <= '0;
      r_minus  <= '0;
      r_lamps  <= '0;
      r_stb    <= 1'b0;
      r_waddr  <= '0;
    end else begin
      r_prev   <= w_pat;
      r_cnt    <= w_cnt_nx;
      for (int i = 1; i <= 12; i++) r_word[i] <= w_word_nx[i];
      r_digits <= w_digits;
      r_plus   <= {w_word_nx[RW_R3MID][10], w_word_nx[RW_R2HI][10], w_word_nx[RW_R1HI][10]};
      r_minus  <= {w_word_nx[RW_R3LO][10],  w_word_nx[RW_R2LO][10], w_word_nx[RW_R1LO][10]};
      r_lamps  <= w_word_nx[RW_LAMPS];
      r_stb    <= w_accept;
      if (w_accept) r_waddr <= w_addr;
    end
  end

  assign DSKY_DIGITS = r_digits;
  assign DSKY_PLUS   = r_plus;
  assign DSKY_MINUS  = r_minus;
  assign DSKY_LAMPS  = r_lamps;
  assign WORD_STB    = r_stb;
  assign WORD_ADDR   = r_waddr;

endmodule

// File: tb/tb_dsky_relay_decoder.sv
// Scoreboarded bench for dsky_relay_decoder: expected strobes (cycle, address)
// are queued at drive time and matched against strobes seen on WORD_STB.
module tb_dsky_relay_decoder;
  import dsky_pkg::*;

  localparam int STABLE = 16;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + STABLE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [83:0] digits;
  logic [2:0]  plus, minus;
  logic [10:0] lamps;
  logic        stb;
  logic [3:0]  waddr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int         exp_cyc[$];
  logic [3:0] exp_addr[$];
  int         obs_cyc[$];
  logic [3:0] obs_addr[$];
  logic [83:0] all_blank = {21{4'hF}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsky_relay_decoder_if rif ();

  dsky_relay_decoder #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
    .SIM_CLK     (clk),
    .SIM_RST_n   (rst_n),
    .relay       (rif),
    .DSKY_DIGITS (digits),
    .DSKY_PLUS   (plus),
    .DSKY_MINUS  (minus),
    .DSKY_LAMPS  (lamps),
    .WORD_STB    (stb),
    .WORD_ADDR   (waddr)
  );

  always @(negedge clk) begin
    if (stb === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_addr.push_back(waddr);
    end
  end

  function automatic logic [3:0] dig(input int i);
    return digits[4*i +: 4];
  endfunction

  task automatic set_relay(input logic [3:0] a, input logic [10:0] d);
    {rif.RYWD16, rif.RYWD14, rif.RYWD13, rif.RYWD12} = a;
    {rif.RLYB11, rif.RLYB10, rif.RLYB09, rif.RLYB08, rif.RLYB07, rif.RLYB06,
     rif.RLYB05, rif.RLYB04, rif.RLYB03, rif.RLYB02, rif.RLYB01} = d;
  endtask

  task automatic drive(input logic [3:0] a, input logic [10:0] d, input int hold, input bit acc);
    set_relay(a, d);
    if (acc) begin
      exp_cyc.push_back(cyc + LAT);
      exp_addr.push_back(a);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset;
    rif.VNFLSH = 1'b0;
    set_relay(4'd0, 11'd0);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (digits !== all_blank) begin miscompares++; $display("FAIL reset_digits: got %h want %h", digits, all_blank); end
    vectors++; if (plus !== 3'b000 || minus !== 3'b000) begin miscompares++; $display("FAIL reset_signs: got %b/%b want 000/000", plus, minus); end
    vectors++; if (lamps !== 11'd0) begin miscompares++; $display("FAIL reset_lamps: got %h want 000", lamps); end
    vectors++; if (stb !== 1'b0 || waddr !== 4'd0) begin miscompares++; $display("FAIL reset_stb: got stb=%b addr=%0d want 0/0", stb, waddr); end
    obs_cyc.delete(); obs_addr.delete();
  endtask

  task automatic test_program;
    drive(RW_MODE, 11'h075, 40, 1'b1);
    vectors++; if (obs_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL prog_count: got %0d strobes want %0d", obs_cyc.size(), exp_cyc.size()); end
    while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
      vectors++;
      if (obs_cyc[0] != exp_cyc[0] || obs_addr[0] !== exp_addr[0]) begin miscompares++;
        $display("FAIL prog_strobe: got cycle %0d addr %0d want cycle %0d addr %0d", obs_cyc[0], obs_addr[0], exp_cyc[0], exp_addr[0]); end
      void'(exp_cyc.pop_front()); void'(exp_addr.pop_front()); void'(obs_cyc.pop_front()); void'(obs_addr.pop_front());
    end
    exp_cyc.delete(); exp_addr.delete(); obs_cyc.delete(); obs_addr.delete();
    vectors++; if (dig(DG_MD1) !== 4'd1 || dig(DG_MD2) !== 4'd0) begin miscompares++; $display("FAIL prog_md: got %h%h want 10", dig(DG_MD1), dig(DG_MD2)); end
    vectors++; if (digits[83:8] !== all_blank[83:8]) begin miscompares++; $display("FAIL prog_others: got %h want all F", digits[83:8]); end
    vectors++; if (waddr !== RW_MODE) begin miscompares++; $display("FAIL prog_addr: got %0d want 11", waddr); end
  endtask

  task automatic test_glitch;
    drive(RW_VERB, 11'h2B9, STABLE - 2, 1'b0);
    drive(4'd0, 11'd0, 40, 1'b0);
    vectors++; if (obs_cyc.size() != 0) begin miscompares++; $display("FAIL glitch_count: got %0d strobes want 0", obs_cyc.size()); end
    obs_cyc.delete(); obs_addr.delete();
    vectors++; if (dig(DG_VD1) !== 4'hF || dig(DG_VD2) !== 4'hF) begin miscompares++; $display("FAIL glitch_verb: got %h%h want FF", dig(DG_VD1), dig(DG_VD2)); end
  endtask

  task automatic test_signs;
    drive(RW_R1HI, 11'h400, 40, 1'b1);
    drive(RW_R1LO, 11'h400, 40, 1'b1);
    vectors++; if (obs_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL sign_count: got %0d strobes want %0d", obs_cyc.size(), exp_cyc.size()); end
    while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
      vectors++;
      if (obs_cyc[0] != exp_cyc[0] || obs_addr[0] !== exp_addr[0]) begin miscompares++;
        $display("FAIL sign_strobe: got cycle %0d addr %0d want cycle %0d addr %0d", obs_cyc[0], obs_addr[0], exp_cyc[0], exp_addr[0]); end
      void'(exp_cyc.pop_front()); void'(exp_addr.pop_front()); void'(obs_cyc.pop_front()); void'(obs_addr.pop_front());
    end
    exp_cyc.delete(); exp_addr.delete(); obs_cyc.delete(); obs_addr.delete();
    vectors++; if (plus !== 3'b001 || minus !== 3'b001) begin miscompares++; $display("FAIL sign_bits: got %b/%b want 001/001", plus, minus); end
    vectors++; if ({dig(DG_R1D2), dig(DG_R1D3), dig(DG_R1D4), dig(DG_R1D5)} !== 16'hFFFF) begin miscompares++;
      $display("FAIL sign_digits: got %h%h%h%h want FFFF", dig(DG_R1D2), dig(DG_R1D3), dig(DG_R1D4), dig(DG_R1D5)); end
  endtask

  task automatic test_invalid;
    drive(RW_NOUN, 11'h0A5, 40, 1'b1);
    drive(4'd14, 11'h7FF, 40, 1'b0);
    drive(4'd13, 11'h555, 40, 1'b0);
    drive(4'd15, 11'h2AA, 40, 1'b0);
    vectors++; if (obs_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL inv_count: got %0d strobes want %0d", obs_cyc.size(), exp_cyc.size()); end
    while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
      vectors++;
      if (obs_cyc[0] != exp_cyc[0] || obs_addr[0] !== exp_addr[0]) begin miscompares++;
        $display("FAIL inv_strobe: got cycle %0d addr %0d want cycle %0d addr %0d", obs_cyc[0], obs_addr[0], exp_cyc[0], exp_addr[0]); end
      void'(exp_cyc.pop_front()); void'(exp_addr.pop_front()); void'(obs_cyc.pop_front()); void'(obs_addr.pop_front());
    end
    exp_cyc.delete(); exp_addr.delete(); obs_cyc.delete(); obs_addr.delete();
    vectors++; if (dig(DG_ND1) !== 4'hE || dig(DG_ND2) !== 4'hE) begin miscompares++; $display("FAIL inv_noun: got %h%h want EE", dig(DG_ND1), dig(DG_ND2)); end
    vectors++; if (dig(DG_MD1) !== 4'd1 || lamps !== 11'd0 || waddr !== RW_NOUN) begin miscompares++;
      $display("FAIL inv_nochange: got md1=%h lamps=%h addr=%0d want 1/000/9", dig(DG_MD1), lamps, waddr); end
  endtask

  task automatic test_back_to_back;
    drive(RW_LAMPS, 11'h5A5, 40, 1'b1);
    drive(4'd0, 11'd0, 3, 1'b0);
    drive(RW_LAMPS, 11'h5A5, 40, 1'b1);
    drive(RW_R2R3, {1'b0, RC_4, RC_8}, 40, 1'b1);
    vectors++; if (obs_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL b2b_count: got %0d strobes want %0d", obs_cyc.size(), exp_cyc.size()); end
    while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
      vectors++;
      if (obs_cyc[0] != exp_cyc[0] || obs_addr[0] !== exp_addr[0]) begin miscompares++;
        $display("FAIL b2b_strobe: got cycle %0d addr %0d want cycle %0d addr %0d", obs_cyc[0], obs_addr[0], exp_cyc[0], exp_addr[0]); end
      void'(exp_cyc.pop_front()); void'(exp_addr.pop_front()); void'(obs_cyc.pop_front()); void'(obs_addr.pop_front());
    end
    exp_cyc.delete(); exp_addr.delete(); obs_cyc.delete(); obs_addr.delete();
    vectors++; if (lamps !== 11'h5A5) begin miscompares++; $display("FAIL b2b_lamps: got %h want 5a5", lamps); end
    vectors++; if (dig(DG_R2D5) !== 4'd4 || dig(DG_R3D1) !== 4'd8) begin miscompares++; $display("FAIL b2b_r2r3: got %h%h want 48", dig(DG_R2D5), dig(DG_R3D1)); end
  endtask

  task automatic test_flash;
    drive(RW_VERB, {1'b0, RC_3, RC_7}, 40, 1'b1);
    vectors++; if (dig(DG_VD1) !== 4'd3 || dig(DG_VD2) !== 4'd7) begin miscompares++; $display("FAIL flash_verb: got %h%h want 37", dig(DG_VD1), dig(DG_VD2)); end
    rif.VNFLSH = 1'b1;
    repeat (6) @(negedge clk);
`ifdef VNFLSH_BLANK_EN
    vectors++; if ({dig(DG_VD1), dig(DG_VD2), dig(DG_ND1), dig(DG_ND2)} !== 16'hFFFF) begin miscompares++;
      $display("FAIL flash_on: got %h%h%h%h want FFFF", dig(DG_VD1), dig(DG_VD2), dig(DG_ND1), dig(DG_ND2)); end
`else
    vectors++; if ({dig(DG_VD1), dig(DG_VD2), dig(DG_ND1), dig(DG_ND2)} !== 16'h37EE) begin miscompares++;
      $display("FAIL flash_on: got %h%h%h%h want 37EE", dig(DG_VD1), dig(DG_VD2), dig(DG_ND1), dig(DG_ND2)); end
`endif
    vectors++; if (dig(DG_MD1) !== 4'd1) begin miscompares++; $display("FAIL flash_mode: got %h want 1", dig(DG_MD1)); end
    rif.VNFLSH = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if ({dig(DG_VD1), dig(DG_VD2), dig(DG_ND1), dig(DG_ND2)} !== 16'h37EE) begin miscompares++;
      $display("FAIL flash_off: got %h%h%h%h want 37EE", dig(DG_VD1), dig(DG_VD2), dig(DG_ND1), dig(DG_ND2)); end
    vectors++; if (obs_cyc.size() != exp_cyc.size()) begin miscompares++; $display("FAIL flash_count: got %0d strobes want %0d", obs_cyc.size(), exp_cyc.size()); end
    while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
      vectors++;
      if (obs_cyc[0] != exp_cyc[0] || obs_addr[0] !== exp_addr[0]) begin miscompares++;
        $display("FAIL flash_strobe: got cycle %0d addr %0d want cycle %0d addr %0d", obs_cyc[0], obs_addr[0], exp_cyc[0], exp_addr[0]); end
      void'(exp_cyc.pop_front()); void'(exp_addr.pop_front()); void'(obs_cyc.pop_front()); void'(obs_addr.pop_front());
    end
    exp_cyc.delete(); exp_addr.delete(); obs_cyc.delete(); obs_addr.delete();
  endtask

  task automatic test_reset_mid;
    drive(RW_R2HI, {1'b1, RC_2, RC_6}, 5, 1'b0);
    rst_n = 1'b0;
    set_relay(4'd0, 11'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    vectors++; if (obs_cyc.size() != 0) begin miscompares++; $display("FAIL rmid_count: got %0d strobes want 0", obs_cyc.size()); end
    obs_cyc.delete(); obs_addr.delete();
    vectors++; if (digits !== all_blank) begin miscompares++; $display("FAIL rmid_digits: got %h want %h", digits, all_blank); end
    vectors++; if (plus !== 3'b000 || minus !== 3'b000 || lamps !== 11'd0) begin miscompares++;
      $display("FAIL rmid_misc: got %b/%b/%h want 000/000/000", plus, minus, lamps); end
    vectors++; if (stb !== 1'b0 || waddr !== 4'd0) begin miscompares++; $display("FAIL rmid_stb: got stb=%b addr=%0d want 0/0", stb, waddr); end
  endtask

  initial begin
    rif.VNFLSH = 1'b0;
    set_relay(4'd0, 11'd0);
    @(negedge clk);
    test_reset();
    test_program();
    test_glitch();
    test_signs();
    test_invalid();
    test_back_to_back();
    test_flash();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsky_relay_decoder.md
# dsky_relay_decoder

Captures the AGC's DSKY relay-word outputs (RYWD12/13/14/16 address, RLYB01–RLYB11 data) and rebuilds the DSKY display state. Sits directly downstream of the agc top level in the simulation and FPGA builds, taking its place as the DSKY. Filters the asynchronous, glitch-prone relay lines and latches each accepted relay word into a 12-entry word file. Decodes the word file into BCD digits, register signs and indicator lamps for display models and bench checkers.

## Interface
- STABLE_CYCLES, 16: consecutive SIM_CLK cycles a synchronized relay pattern must hold before it is accepted (range 1–255).
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer (range 2–3).
- SIM_CLK  in  1  sole clock; all state updates on the rising edge.
- SIM_RST_n  in  1  reset, synchronous, active-low.
- RYWD12, RYWD13, RYWD14, RYWD16  in  1 each  relay-word address bits; address = {RYWD16,RYWD14,RYWD13,RYWD12}.
- RLYB01..RLYB11  in  1 each  relay data bits; data[10:0] = {RLYB11..RLYB01}.
- VNFLSH  in  1  verb/noun flash drive from the AGC.
- DSKY_DIGITS  out  84  21 digits × 4 bits. Digit i is at [4i+3:4i], in order MD1, MD2, VD1, VD2, ND1, ND2, R1D1–R1D5, R2D1–R2D5, R3D1–R3D5.
- DSKY_PLUS  out  3  +sign of R1, R2, R3 (bit 0 = R1).
- DSKY_MINUS  out  3  −sign of R1, R2, R3.
- DSKY_LAMPS  out  11  raw data of relay word 12.
- WORD_STB  out  1  one-cycle pulse on each accepted word.
- WORD_ADDR  out  4  address of the last accepted word.

## Operation
- All 15 relay inputs and VNFLSH pass through SYNC_STAGES flip-flops. Together they form the 15-bit synchronized pattern P = {addr, data}.
- The stability filter keeps the previous pattern and an 8-bit counter:
  - If P differs from the previous pattern, the counter clears to 0.
  - Otherwise the counter increments, saturating at 255.
- Acceptance happens exactly once per distinct pattern: on the cycle the counter reaches STABLE_CYCLES−1 and addr is in 1..12.
- On acceptance: word_file[addr] ← data, WORD_STB = 1, WORD_ADDR = addr.
- addr 0 and addr 13..15 are never stored, never strobed, and leave the word file unchanged.
- Word-file to display mapping (d = data):
  - Word 11: MD1 = d[9:5], MD2 = d[4:0].
  - Word 10: VD1, VD2.
  - Word 9: ND1, ND2.
  - Word 8: R1D1 = d[4:0].
  - Word 7: +R1 = d[10], R1D2, R1D3.
  - Word 6: −R1 = d[10], R1D4, R1D5.
  - Word 5: +R2, R2D1, R2D2.
  - Word 4: −R2, R2D3, R2D4.
  - Word 3: R2D5, R3D1.
  - Word 2: +R3, R3D2, R3D3.
  - Word 1: −R3, R3D4, R3D5.
  - Word 12: DSKY_LAMPS = d.
  - In the two-digit words, the first digit is d[9:5] and the second is d[4:0].
- 5-bit relay code to BCD:
  - 21→0, 3→1, 25→2, 27→3, 15→4, 30→5, 28→6, 19→7, 29→8, 31→9.
  - 0→0xF (blank).
  - Any other code→0xE (invalid).
- Sign bits are stored per word, so plus and minus are independent. Both may be 1.
- Reset (SIM_RST_n = 0 at an edge):
  - Word file, synchronizers, previous pattern and counter all clear.
  - DSKY_DIGITS = all 0xF; DSKY_PLUS, DSKY_MINUS, DSKY_LAMPS, WORD_STB and WORD_ADDR = 0.
  - A word being filtered when reset asserts is discarded.

## Timing
- Latency from an input change to WORD_STB = SYNC_STAGES + STABLE_CYCLES cycles. The decoded outputs update in the same cycle as WORD_STB.
- All outputs are registered. No combinational path runs from the relay inputs to any output.
- A glitch shorter than STABLE_CYCLES restarts the filter and causes no acceptance.
- If the pattern returns to a previously accepted value after a change, it is accepted again (rewrite of identical data).
- Address and data changing in the same cycle is one pattern change.

## Configuration
- VNFLSH_BLANK_EN defined:
  - While synchronized VNFLSH = 1, the VD1, VD2, ND1 and ND2 fields of DSKY_DIGITS read 0xF.
  - The word file is unaffected, and the digits reappear the cycle after VNFLSH drops.
- VNFLSH_BLANK_EN undefined:
  - VNFLSH is synchronized but ignored, and the digits always show the word-file contents.

## Structure
- Package dsky_pkg holds:
  - relay-word address constants RW_R3LO = 1 … RW_MODE = 11, RW_LAMPS = 12;
  - the ten relay code constants and DIGIT_BLANK = 4'hF, DIGIT_BAD = 4'hE;
  - digit index constants for the DSKY_DIGITS ordering.
- Sub-module dsky_digit_decode is the 5-bit code → 4-bit BCD converter, instantiated 21 times.

## Test plan
- Reset: hold SIM_RST_n = 0 for 4 cycles, release → DSKY_DIGITS = all 0xF, DSKY_PLUS = DSKY_MINUS = 0, DSKY_LAMPS = 0, WORD_STB = 0.
- Program word: addr 11, data 11'h075 held 40 cycles → exactly one WORD_STB, SYNC_STAGES+STABLE_CYCLES cycles after the change; MD1 = 1, MD2 = 0.
- Glitch rejection: addr 10, data 11'h2B9 for STABLE_CYCLES−2 cycles, then addr 0 → no WORD_STB; VD1 and VD2 stay 0xF.
- Signs: addr 7 with data 11'h400, then addr 6 with data 11'h400 → DSKY_PLUS[0] = 1 and DSKY_MINUS[0] = 1; R1D2–R1D5 = 0xF.
- Invalid and out-of-range input: addr 9 with data 11'h0A5 → ND1 = 0xE, ND2 = 0xE; then addr 14 with any data → no WORD_STB and no change.
- Flash and reset mid-filter: with VNFLSH_BLANK_EN defined, verb set to 37 and VNFLSH = 1 → VD1/VD2 = 0xF; VNFLSH = 0 → 3, 7. Assert reset 5 cycles into a stable word → no WORD_STB, all outputs at reset values.
